// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-requester block-RAM controller.
package mem_arb_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int AW_DEF = 2;
  localparam int DW_DEF = 8;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

  // After any grant the other requester gets priority on the next tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ptr <= 1'b0;
    else if (adv) ptr <= gnt[0];
  end

endmodule

// File: rtl/mem_arb.sv
// Clears the RAM after reset, then serves two valid/ready ports one access per cycle.
// Handshake: a transfer happens in any cycle where valid && ready; ready depends
// combinationally on both valids and the arbiter pointer, and requesters hold
// we/addr/wdata stable while valid is high and ready is low.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_valid,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  output logic          req0_ready,
  output logic          resp0_valid,
  output logic [DW-1:0] resp0_rdata,
  input  logic          req1_valid,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          req1_ready,
  output logic          resp1_valid,
  output logic [DW-1:0] resp1_rdata,
  output logic          init_done,
  output logic          mem_ce,
  output logic          mem_wre,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_din,
  output logic          mem_oce,
  output logic          mem_reset,
  input  logic [DW-1:0] mem_dout,
  output state_t        dbg_state
);

  localparam logic [AW-1:0] LAST = AW'(depth(AW) - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [1:0]    gnt;
  logic          xfer, sel, sel_we;
  logic          rd_pend, rd_tag;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({req1_valid, req0_valid} & {2{state == RUN}}),
    .adv     (xfer),
    .gnt     (gnt)
  );

  assign xfer   = |gnt;
  assign sel    = gnt[1];
  assign sel_we = sel ? req1_we : req0_we;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= INIT;
      cnt     <= '0;
      rd_pend <= 1'b0;
      rd_tag  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_pend <= xfer && !sel_we;
      rd_tag  <= sel;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        cnt_nxt = cnt + AW'(1);
        if (cnt == LAST) state_nxt = RUN;
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  // RAM mux: clear writes in INIT, granted port in RUN; reset silences the strobes.
  always_comb begin
    mem_ce  = 1'b0;
    mem_wre = 1'b0;
    mem_ad  = '0;
    mem_din = '0;
    if (state == INIT) begin
      mem_ce  = 1'b1;
      mem_wre = 1'b1;
      mem_ad  = cnt;
      mem_din = INIT_VAL;
    end else if (xfer) begin
      mem_ce  = 1'b1;
      mem_wre = sel_we;
      mem_ad  = sel ? req1_addr : req0_addr;
      mem_din = sel ? req1_wdata : req0_wdata;
    end
    if (!reset_n) begin
      mem_ce  = 1'b0;
      mem_wre = 1'b0;
    end
  end

  assign req0_ready  = gnt[0];
  assign req1_ready  = gnt[1];
  assign resp0_valid = rd_pend && !rd_tag;
  assign resp1_valid = rd_pend && rd_tag;
  assign resp0_rdata = mem_dout;
  assign resp1_rdata = mem_dout;
  assign init_done   = (state == RUN);
  assign mem_oce     = 1'b1;
  assign mem_reset   = 1'b0;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural 4x8 synchronous-read RAM attached.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          req0_valid = 1'b0, req0_we = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_wdata = '0;
  logic          req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_wdata = '0;
  logic          req0_ready, resp0_valid, req1_ready, resp1_valid;
  logic [DW-1:0] resp0_rdata, resp1_rdata;
  logic          init_done, mem_ce, mem_wre, mem_oce, mem_reset;
  logic [AW-1:0] mem_ad;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = 8'hEE;
  state_t        dbg_state;

  int checks = 0;
  int failures = 0;

  // clock/reset block
  always #5 clk = ~clk;

  mem_arb #(.AW(AW), .DW(DW), .INIT_VAL(8'h00)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
    .init_done(init_done), .mem_ce(mem_ce), .mem_wre(mem_wre),
    .mem_ad(mem_ad), .mem_din(mem_din), .mem_oce(mem_oce),
    .mem_reset(mem_reset), .mem_dout(mem_dout), .dbg_state(dbg_state)
  );

  // RAM model: starts with junk so the clear sequence is observable.
  logic [DW-1:0] ram [4] = '{8'hEE, 8'hEE, 8'hEE, 8'hEE};
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_wre) ram[mem_ad] <= mem_din;
      else         mem_dout    <= ram[mem_ad];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the edge, checks happen 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
  endtask

  task automatic init_seq(input string tag);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk({tag, "_ce"}, 32'(mem_ce), 32'd1);
      chk({tag, "_wre"}, 32'(mem_wre), 32'd1);
      chk({tag, "_ad"}, 32'(mem_ad), 32'(i));
      chk({tag, "_din"}, 32'(mem_din), 32'h00);
      chk({tag, "_rdy0"}, 32'(req0_ready), 32'd0);
      chk({tag, "_done"}, 32'(init_done), 32'd0);
      tick();
    end
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_ce", 32'(mem_ce), 32'd0);
    chk("rst_wre", 32'(mem_wre), 32'd0);
    chk("rst_rdy0", 32'(req0_ready), 32'd0);
    chk("rst_rsp0", 32'(resp0_valid), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_oce", 32'(mem_oce), 32'd1);
    chk("rst_mreset", 32'(mem_reset), 32'd0);
    tick();
    reset_n = 1'b1;
    drive0(1'b1, 1'b0, 2'd2, 8'h00);  // held through INIT, must not be accepted
    init_seq("init");

    // First RUN cycle: read addr 2
    #1;
    chk("run_done", 32'(init_done), 32'd1);
    chk("rd2_rdy0", 32'(req0_ready), 32'd1);
    chk("rd2_wre", 32'(mem_wre), 32'd0);
    chk("rd2_ad", 32'(mem_ad), 32'd2);
    tick();
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("rd2_rsp0", 32'(resp0_valid), 32'd1);
    chk("rd2_data", 32'(resp0_rdata), 32'h00);
    chk("rd2_rsp1", 32'(resp1_valid), 32'd0);
    tick();

    // Write then read-after-write on req0
    drive0(1'b1, 1'b1, 2'd1, 8'hA5);
    #1;
    chk("wr1_rdy0", 32'(req0_ready), 32'd1);
    chk("wr1_wre", 32'(mem_wre), 32'd1);
    chk("wr1_din", 32'(mem_din), 32'hA5);
    chk("wr1_rsp0", 32'(resp0_valid), 32'd0);
    tick();
    drive0(1'b1, 1'b0, 2'd1, 8'h00);
    #1;
    chk("raw_rdy0", 32'(req0_ready), 32'd1);
    chk("raw_nowrsp", 32'(resp0_valid), 32'd0);
    tick();
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("raw_rsp0", 32'(resp0_valid), 32'd1);
    chk("raw_data", 32'(resp0_rdata), 32'hA5);
    chk("raw_rsp1", 32'(resp1_valid), 32'd0);
    tick();
    #1;
    chk("raw_pulse", 32'(resp0_valid), 32'd0);

    // Preload addr0=11 (req0), addr3=33 (req1)
    drive0(1'b1, 1'b1, 2'd0, 8'h11);
    #1;
    chk("pre0_rdy0", 32'(req0_ready), 32'd1);
    tick();
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    drive1(1'b1, 1'b1, 2'd3, 8'h33);
    #1;
    chk("pre1_rdy1", 32'(req1_ready), 32'd1);
    tick();

    // Both reading continuously: grants alternate starting with req0
    drive0(1'b1, 1'b0, 2'd0, 8'h00);
    drive1(1'b1, 1'b0, 2'd3, 8'h00);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_rdy0", 32'(req0_ready), 32'(k % 2 == 0));
      chk("alt_rdy1", 32'(req1_ready), 32'(k % 2 == 1));
      chk("alt_rsp0", 32'(resp0_valid), 32'(k % 2 == 1));
      chk("alt_rsp1", 32'(resp1_valid), 32'(k != 0 && k % 2 == 0));
      if (k == 1) chk("alt_d0", 32'(resp0_rdata), 32'h11);
      if (k == 2) chk("alt_d1", 32'(resp1_rdata), 32'h33);
      tick();
    end
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    drive1(1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("alt_last_rsp1", 32'(resp1_valid), 32'd1);
    chk("alt_last_d1", 32'(resp1_rdata), 32'h33);
    chk("alt_last_rsp0", 32'(resp0_valid), 32'd0);
    tick();

    // Only req1 valid for 5 cycles
    drive1(1'b1, 1'b0, 2'd3, 8'h00);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("solo_rdy1", 32'(req1_ready), 32'd1);
      chk("solo_rdy0", 32'(req0_ready), 32'd0);
      chk("solo_rsp1", 32'(resp1_valid), 32'(k > 0));
      tick();
    end
    drive1(1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("solo_last_rsp1", 32'(resp1_valid), 32'd1);
    chk("solo_last_d1", 32'(resp1_rdata), 32'h33);
    tick();

    // Reset pulsed during INIT cycle 2
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("mid_ad", 32'(mem_ad), 32'(i));
      tick();
    end
    #1;
    chk("mid_ad2", 32'(mem_ad), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("mid_ce_async", 32'(mem_ce), 32'd0);
    chk("mid_wre_async", 32'(mem_wre), 32'd0);
    tick();
    reset_n = 1'b1;
    init_seq("reinit");
    #1;
    chk("reinit_done", 32'(init_done), 32'd1);
    drive0(1'b1, 1'b0, 2'd3, 8'h00);
    tick();
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    chk("clear3_rsp0", 32'(resp0_valid), 32'd1);
    chk("clear3_data", 32'(resp0_rdata), 32'h00);
    tick();

    // Pending read dropped by reset; ptr back to 0 afterwards
    drive0(1'b1, 1'b0, 2'd1, 8'h00);
    #1;
    chk("drop_rdy0", 32'(req0_ready), 32'd1);
    tick();
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    #1;
    reset_n = 1'b0;
    #1;
    chk("drop_rsp0", 32'(resp0_valid), 32'd0);
    chk("drop_done", 32'(init_done), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    drive0(1'b1, 1'b0, 2'd0, 8'h00);
    drive1(1'b1, 1'b0, 2'd3, 8'h00);
    #1;
    chk("post_done", 32'(init_done), 32'd1);
    chk("post_rdy0", 32'(req0_ready), 32'd1);
    chk("post_rdy1", 32'(req1_ready), 32'd0);
    tick();
    drive0(1'b0, 1'b0, 2'd0, 8'h00);
    drive1(1'b0, 1'b0, 2'd0, 8'h00);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
